stream_demux2: RTL and testbench

STREAM_DEMUX2 -- requirements
Module: stream_demux2

---
 rtl/stream_demux2_if.sv | 36 +++
 rtl/stream_demux2.sv | 119 +++++++++++
 tb/tb_stream_demux2.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux2_if.sv
// Bundle of upstream and downstream stream signals for the two-way packet demultiplexer.
// The master side feeds beats in and consumes both outputs; the slave side is the demux.
interface stream_demux2_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_sel;
    logic              s_last;

    logic              m0_valid;
    logic              m0_ready;
    logic [DATA_W-1:0] m0_data;
    logic              m0_last;

    logic              m1_valid;
    logic              m1_ready;
    logic [DATA_W-1:0] m1_data;
    logic              m1_last;

    logic [7:0]        pkt_cnt0;
    logic [7:0]        pkt_cnt1;

    modport master (
        output s_valid, s_data, s_sel, s_last, m0_ready, m1_ready,
        input  s_ready, m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last,
        input  pkt_cnt0, pkt_cnt1
    );

    modport slave (
        input  s_valid, s_data, s_sel, s_last, m0_ready, m1_ready,
        output s_ready, m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last,
        output pkt_cnt0, pkt_cnt1
    );
endinterface

// File: rtl/stream_demux2.sv
// Routes whole packets from one stream input to one of two outputs, chosen by s_sel on the
// first beat; each output has its own 2-entry FIFO so a stalled output never blocks the other.
module stream_demux2 #(
    parameter int DATA_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    stream_demux2_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } route_state_t;

    route_state_t      state_reg;
    logic              target;
    logic              accept;
    logic [1:0]        m_ready;
    logic [1:0]        m_valid;
    logic [1:0]        m_last;
    logic [1:0]        fifo_full;
    logic [DATA_W-1:0] m_data [2];
    logic [7:0]        pkt_cnt [2];

    always_comb begin
        target = bus.s_sel;
        case (state_reg)
            LOCK0:   target = 1'b0;
            LOCK1:   target = 1'b1;
            default: target = bus.s_sel;
        endcase
    end

    // Ready only looks at the targeted FIFO; a pop in the same cycle does not free a full one.
    assign bus.s_ready = rst_n && !fifo_full[target];
    assign accept      = bus.s_valid && bus.s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else if (accept) begin
            case (state_reg)
                IDLE: begin
                    if (!bus.s_last) begin
                        state_reg <= bus.s_sel ? LOCK1 : LOCK0;
                    end
                end
                LOCK0, LOCK1: begin
                    if (bus.s_last) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m_ready = {bus.m1_ready, bus.m0_ready};

    for (genvar gi = 0; gi < 2; gi++) begin : g_out
        logic [DATA_W-1:0] data_mem [2];
        logic [1:0]        last_mem;
        logic              rd_ptr_reg;
        logic              wr_ptr_reg;
        logic [1:0]        count_reg;
        logic [7:0]        pkt_cnt_reg;
        logic              push;
        logic              pop;

        assign push = accept && (target == 1'(gi));
        assign pop  = m_valid[gi] && m_ready[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_mem[0] <= '0;
                data_mem[1] <= '0;
                last_mem    <= '0;
                rd_ptr_reg  <= 1'b0;
                wr_ptr_reg  <= 1'b0;
                count_reg   <= 2'd0;
                pkt_cnt_reg <= 8'd0;
            end else begin
                if (push) begin
                    data_mem[wr_ptr_reg] <= bus.s_data;
                    last_mem[wr_ptr_reg] <= bus.s_last;
                    wr_ptr_reg           <= ~wr_ptr_reg;
                    if (bus.s_last) begin
                        pkt_cnt_reg <= pkt_cnt_reg + 8'd1;
                    end
                end
                if (pop) begin
                    rd_ptr_reg <= ~rd_ptr_reg;
                end
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + 2'd1;
                    2'b01:   count_reg <= count_reg - 2'd1;
                    default: count_reg <= count_reg;
                endcase
            end
        end

        // Outputs come straight from storage so nothing on s_* reaches m*_* combinationally.
        assign m_valid[gi]   = (count_reg != 2'd0);
        assign fifo_full[gi] = (count_reg == 2'd2);
        assign m_data[gi]    = data_mem[rd_ptr_reg];
        assign m_last[gi]    = last_mem[rd_ptr_reg];
        assign pkt_cnt[gi]   = pkt_cnt_reg;
    end

    assign bus.m0_valid = m_valid[0];
    assign bus.m0_data  = m_data[0];
    assign bus.m0_last  = m_last[0];
    assign bus.m1_valid = m_valid[1];
    assign bus.m1_data  = m_data[1];
    assign bus.m1_last  = m_last[1];
    assign bus.pkt_cnt0 = pkt_cnt[0];
    assign bus.pkt_cnt1 = pkt_cnt[1];
endmodule

// File: tb/tb_stream_demux2.sv
// Scoreboard bench for stream_demux2: directed packet scenarios followed by random traffic,
// checked against a packet-level model (one queue of expected beats per output).
module tb_stream_demux2;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_demux2_if #(.DATA_W(DATA_W)) bus ();

    stream_demux2 #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: expected {last, data} per output, current packet destination, packet counts.
    logic [DATA_W:0] q0 [$];
    logic [DATA_W:0] q1 [$];
    int  cnt_model [2];
    bit  in_pkt;
    bit  cur_dest;
    int  pushed0;
    int  pushed1;
    bit  accepted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        cnt_model[0] = 0;
        cnt_model[1] = 0;
        in_pkt   = 1'b0;
        cur_dest = 1'b0;
    endtask

    // One clock cycle of stimulus; inputs change on the falling edge, evaluated 2 units later.
    task automatic drive_cycle(input bit v, input logic [DATA_W-1:0] d, input bit sel,
                               input bit last, input bit r0, input bit r1);
        bit tgt;
        int occ;
        @(negedge clk);
        bus.s_valid  = v;
        bus.s_data   = d;
        bus.s_sel    = sel;
        bus.s_last   = last;
        bus.m0_ready = r0;
        bus.m1_ready = r1;
        #2;
        tgt = in_pkt ? cur_dest : sel;
        occ = tgt ? q1.size() : q0.size();
        check("s_ready", {31'd0, bus.s_ready}, {31'd0, (occ < 2)});
        check("pkt_cnt0", {24'd0, bus.pkt_cnt0}, cnt_model[0]);
        check("pkt_cnt1", {24'd0, bus.pkt_cnt1}, cnt_model[1]);
        accepted = v && bus.s_ready;
        if (accepted) begin
            if (tgt) begin
                q1.push_back({last, d});
                pushed1 = 1;
            end else begin
                q0.push_back({last, d});
                pushed0 = 1;
            end
            if (last) begin
                cnt_model[tgt] = (cnt_model[tgt] + 1) % 256;
                in_pkt = 1'b0;
            end else begin
                in_pkt   = 1'b1;
                cur_dest = tgt;
            end
        end
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input bit sel, input bit last,
                             input bit r0, input bit r1);
        int tries;
        tries = 0;
        do begin
            drive_cycle(1'b1, d, sel, last, r0, r1);
            tries++;
        end while (!accepted && tries < 50);
        if (!accepted) begin
            check("send_timeout", 32'd1, 32'd0);
        end
    endtask

    task automatic idle(input int n, input bit r0, input bit r1);
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0, r0, r1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        #2;
        check("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        check("rst_m0_valid", {31'd0, bus.m0_valid}, 32'd0);
        check("rst_m1_valid", {31'd0, bus.m1_valid}, 32'd0);
        check("rst_m0_data", {24'd0, bus.m0_data}, 32'd0);
        check("rst_m1_data", {24'd0, bus.m1_data}, 32'd0);
        check("rst_lasts", {30'd0, bus.m1_last, bus.m0_last}, 32'd0);
        check("rst_cnts", {16'd0, bus.pkt_cnt1, bus.pkt_cnt0}, 32'd0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("ready_after_reset", {31'd0, bus.s_ready}, 32'd1);
    endtask

    // Monitor: every cycle, compare output valid against model occupancy and check popped beats.
    initial begin
        logic [DATA_W:0] exp_beat;
        int exp_n;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                exp_n = q0.size() - pushed0;
                check("m0_valid", {31'd0, bus.m0_valid}, {31'd0, (exp_n > 0)});
                if (bus.m0_valid && bus.m0_ready && q0.size() > 0) begin
                    exp_beat = q0.pop_front();
                    $display("m0 beat data=%02h last=%0b", bus.m0_data, bus.m0_last);
                    check("m0_data", {24'd0, bus.m0_data}, {24'd0, exp_beat[DATA_W-1:0]});
                    check("m0_last", {31'd0, bus.m0_last}, {31'd0, exp_beat[DATA_W]});
                end
                exp_n = q1.size() - pushed1;
                check("m1_valid", {31'd0, bus.m1_valid}, {31'd0, (exp_n > 0)});
                if (bus.m1_valid && bus.m1_ready && q1.size() > 0) begin
                    exp_beat = q1.pop_front();
                    $display("m1 beat data=%02h last=%0b", bus.m1_data, bus.m1_last);
                    check("m1_data", {24'd0, bus.m1_data}, {24'd0, exp_beat[DATA_W-1:0]});
                    check("m1_last", {31'd0, bus.m1_last}, {31'd0, exp_beat[DATA_W]});
                end
            end
            pushed0 = 0;
            pushed1 = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.s_sel    = 1'b0;
        bus.s_last   = 1'b0;
        bus.m0_ready = 1'b0;
        bus.m1_ready = 1'b0;
        pushed0 = 0;
        pushed1 = 0;
        model_clear();
        do_reset();

        // Single-beat packet to m1.
        drive_cycle(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("single_m1_valid", {31'd0, bus.m1_valid}, 32'd1);
        check("single_m1_data", {24'd0, bus.m1_data}, 32'hA5);
        check("single_m1_last", {31'd0, bus.m1_last}, 32'd1);
        check("single_m0_valid", {31'd0, bus.m0_valid}, 32'd0);
        check("single_cnt1", {24'd0, bus.pkt_cnt1}, 32'd1);
        idle(2, 1'b1, 1'b1);

        // Locked packet: s_sel changes after the first beat are ignored.
        send_beat(8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
        send_beat(8'h02, 1'b1, 1'b0, 1'b1, 1'b1);
        send_beat(8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);
        check("lock_cnt0", {24'd0, bus.pkt_cnt0}, 32'd1);
        check("lock_cnt1", {24'd0, bus.pkt_cnt1}, 32'd1);

        // Backpressure on m0.
        send_beat(8'h11, 1'b0, 1'b1, 1'b0, 1'b1);
        send_beat(8'h12, 1'b0, 1'b1, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 1'b1);
        check("bp_ready_low", {31'd0, bus.s_ready}, 32'd0);
        check("bp_hold_data", {24'd0, bus.m0_data}, 32'h11);
        drive_cycle(1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 1'b1);
        check("bp_still_held", {24'd0, bus.m0_data}, 32'h11);
        send_beat(8'h13, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);

        // Isolation: m1 full and stalled, m0 traffic still flows.
        send_beat(8'h21, 1'b1, 1'b1, 1'b1, 1'b0);
        send_beat(8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b1, 8'h31, 1'b0, 1'b1, 1'b1, 1'b0);
        check("iso_ready", {31'd0, bus.s_ready}, 32'd1);
        idle(1, 1'b1, 1'b0);
        check("iso_m1_stalled", {24'd0, bus.m1_data}, 32'h21);
        idle(4, 1'b1, 1'b1);

        // Counter wrap on m0.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_beat(8'(i), 1'b0, 1'b1, 1'b1, 1'b1);
        end
        idle(2, 1'b1, 1'b1);
        check("wrap_cnt0", {24'd0, bus.pkt_cnt0}, 32'd0);

        // Reset in the middle of a locked m1 packet.
        send_beat(8'h41, 1'b1, 1'b0, 1'b1, 1'b0);
        send_beat(8'h42, 1'b1, 1'b0, 1'b1, 1'b0);
        do_reset();
        send_beat(8'h51, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1, 1'b1, 1'b1);
        check("post_rst_m1_valid", {31'd0, bus.m1_valid}, 32'd0);
        check("post_rst_cnt0", {24'd0, bus.pkt_cnt0}, 32'd1);
        idle(2, 1'b1, 1'b1);

        // Random traffic with varying downstream stall rates.
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 500; i++) begin
                drive_cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                            1'($urandom_range(0, 3) == 0),
                            1'($urandom_range(0, 3) >= phase), 1'($urandom_range(0, 3) < 3 - phase));
            end
        end

        // Drain and confirm nothing was left behind or lost.
        for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) begin
            idle(1, 1'b1, 1'b1);
        end
        idle(1, 1'b1, 1'b1);
        check("drain_empty", q0.size() + q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
